synth_40_capture_fifo: RTL and testbench

//  Downstream consumer of the synth_40 register bank. Accepts the registered

---
 rtl/synth_40_pkg.sv | 23 ++
 rtl/synth_40_fifo_mem.sv | 27 ++
 rtl/synth_40_capture_fifo.sv | 101 ++++++++++
 tb/tb_synth_40_capture_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/synth_40_pkg.sv
// Shared field widths and payload layout for the synth_40 register bank
// and its capture FIFO.
package synth_40_pkg;

   localparam int W_A = 32;
   localparam int W_B = 34;
   localparam int W_C = 32;
   localparam int W_D = 37;
   localparam int W_T = 10;

   // Packed MSB-first as {ctl, tag, D, C, B, A}.
   typedef struct packed {
      logic [1:0]     ctl;
      logic [W_T-1:0] tag;
      logic [W_D-1:0] d;
      logic [W_C-1:0] c;
      logic [W_B-1:0] b;
      logic [W_A-1:0] a;
   } synth_40_payload_t;

   localparam int PAYLOAD_W = $bits(synth_40_payload_t);

endpackage

// File: rtl/synth_40_fifo_mem.sv
// FIFO storage: DEPTH x PAYLOAD_W, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module synth_40_fifo_mem
   import synth_40_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 wr_en_i,
   input  logic [AW-1:0]        wr_addr_i,
   input  logic [PAYLOAD_W-1:0] wr_data_i,
   input  logic [AW-1:0]        rd_addr_i,
   output logic [PAYLOAD_W-1:0] rd_data_o
);

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/synth_40_capture_fifo.sv
// First-word-fall-through capture FIFO for the synth_40 field set, with
// occupancy, high-water mark and a sticky drop flag.
module synth_40_capture_fifo
   import synth_40_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic           i1,
   input  logic           i2,
   input  logic           i3,
   input  logic [W_A-1:0] i4,
   input  logic [W_B-1:0] i5,
   input  logic [W_C-1:0] i6,
   input  logic [W_D-1:0] i7,
   input  logic [W_T-1:0] i8,
   input  logic [1:0]     i9,
   input  logic           i10,
   output logic           o1,
   output logic           o2,
   output logic [W_A-1:0] o3,
   output logic [W_B-1:0] o4,
   output logic [W_C-1:0] o5,
   output logic [W_D-1:0] o6,
   output logic [W_T-1:0] o7,
   output logic [1:0]     o8,
   output logic [CW-1:0]  o9,
   output logic           o10,
   output logic [CW-1:0]  o11
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              drop_q, drop_d;
   logic [CW-1:0]     hwm_q, hwm_d;
   logic              push, pop;
   synth_40_payload_t wr_payload, rd_payload, head;

   // Flow control depends only on registered count; no pop-to-push bypass.
   assign o1   = (count_q != FULL_CNT);
   assign o2   = (count_q != '0);
   assign push = i3 & o1;
   assign pop  = o2 & i10;

   assign wr_payload = '{ctl: i9, tag: i8, d: i7, c: i6, b: i5, a: i4};

   synth_40_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk_i     (i1),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_payload),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_payload)
   );

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      drop_d   = drop_q;
      hwm_d    = hwm_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (i3 && !o1) drop_d = 1'b1;
      if (count_d > hwm_q) hwm_d = count_d;
   end

   always_ff @(posedge i1) begin
      if (i2) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
         hwm_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         hwm_q    <= hwm_d;
      end
   end

   // Unwritten storage must never leak out while empty.
   assign head = o2 ? rd_payload : '0;

   assign o3  = head.a;
   assign o4  = head.b;
   assign o5  = head.c;
   assign o6  = head.d;
   assign o7  = head.tag;
   assign o8  = head.ctl;
   assign o9  = count_q;
   assign o10 = drop_q;
   assign o11 = hwm_q;

endmodule

// File: tb/tb_synth_40_capture_fifo.sv
// Directed bench for synth_40_capture_fifo with a payload scoreboard.
module tb_synth_40_capture_fifo;
   import synth_40_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic           clk = 1'b0;
   logic           i2, i3, i10;
   synth_40_payload_t in_pl;
   logic           o1, o2, o10;
   logic [W_A-1:0] o3;
   logic [W_B-1:0] o4;
   logic [W_C-1:0] o5;
   logic [W_D-1:0] o6;
   logic [W_T-1:0] o7;
   logic [1:0]     o8;
   logic [CW-1:0]  o9, o11;

   synth_40_payload_t exp_q[$];
   int mcount = 0;
   int mhwm   = 0;
   bit mdrop  = 1'b0;
   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   synth_40_capture_fifo #(.DEPTH(DEPTH)) dut (
      .i1(clk), .i2(i2), .i3(i3),
      .i4(in_pl.a), .i5(in_pl.b), .i6(in_pl.c), .i7(in_pl.d),
      .i8(in_pl.tag), .i9(in_pl.ctl), .i10(i10),
      .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
      .o8(o8), .o9(o9), .o10(o10), .o11(o11)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input bit v, input bit rdy, input int a, input int tag);
      i3  = v;
      i10 = rdy;
      in_pl.a   = W_A'(a);
      in_pl.b   = W_B'({$urandom, $urandom});
      in_pl.c   = W_C'($urandom);
      in_pl.d   = W_D'({$urandom, $urandom});
      in_pl.tag = W_T'(tag);
      in_pl.ctl = 2'($urandom_range(0, 3));
   endtask

   task automatic check_outputs();
      synth_40_payload_t head_obs, head_exp;
      head_obs = '{ctl: o8, tag: o7, d: o6, c: o5, b: o4, a: o3};
      head_exp = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("in_ready",  160'(o1),  160'(mcount != DEPTH));
      chk("out_valid", 160'(o2),  160'(mcount != 0));
      chk("count",     160'(o9),  160'(mcount));
      chk("drop",      160'(o10), 160'(mdrop));
      chk("hwm",       160'(o11), 160'(mhwm));
      chk("head",      160'(head_obs), 160'(head_exp));
   endtask

   // One clock: model decides push/pop from pre-edge state, then checks after.
   task automatic cycle();
      bit push, pop, dropc;
      push  = i3 && (mcount != DEPTH);
      pop   = (mcount != 0) && i10;
      dropc = i3 && (mcount == DEPTH);
      @(posedge clk);
      if (i2) begin
         exp_q.delete();
         mcount = 0;
         mdrop  = 1'b0;
         mhwm   = 0;
      end else begin
         if (pop)  void'(exp_q.pop_front());
         if (push) exp_q.push_back(in_pl);
         mcount = mcount + int'(push) - int'(pop);
         if (dropc) mdrop = 1'b1;
         if (mcount > mhwm) mhwm = mcount;
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      // 1. reset and idle
      i2 = 1'b1;
      set_in(1'b0, 1'b0, 0, 0);
      cycle();
      cycle();
      i2 = 1'b0;
      cycle();
      chk("t1_ready", 160'(o1), 160'(1));
      chk("t1_head_a", 160'(o3), 160'(0));

      // 2. single word, latency one, then pop
      set_in(1'b1, 1'b0, 1, 3);
      cycle();
      chk("t2_valid", 160'(o2), 160'(1));
      chk("t2_a", 160'(o3), 160'(1));
      chk("t2_tag", 160'(o7), 160'(3));
      chk("t2_count", 160'(o9), 160'(1));
      set_in(1'b0, 1'b1, 0, 0);
      cycle();
      chk("t2_empty", 160'(o2), 160'(0));
      chk("t2_count0", 160'(o9), 160'(0));

      // 3. fill, overflow attempt, drain in order
      for (int k = 1; k <= 4; k++) begin
         set_in(1'b1, 1'b0, k, k + 16);
         cycle();
      end
      chk("t3_full_cnt", 160'(o9), 160'(4));
      chk("t3_full_rdy", 160'(o1), 160'(0));
      chk("t3_hwm", 160'(o11), 160'(4));
      set_in(1'b1, 1'b0, 5, 5);
      cycle();
      chk("t3_drop", 160'(o10), 160'(1));
      chk("t3_nostore", 160'(o9), 160'(4));
      for (int k = 1; k <= 4; k++) begin
         chk("t3_order", 160'(o3), 160'(k));
         set_in(1'b0, 1'b1, 0, 0);
         cycle();
      end
      chk("t3_drained", 160'(o2), 160'(0));

      // 4. steady push+pop at count 2, pointers wrap
      for (int k = 0; k < 2; k++) begin
         set_in(1'b1, 1'b0, 32'h40 + k, k);
         cycle();
      end
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 1'b1, 32'h100 + k, $urandom_range(0, 1023));
         cycle();
         chk("t4_count", 160'(o9), 160'(2));
      end
      for (int k = 0; k < 2; k++) begin
         set_in(1'b0, 1'b1, 0, 0);
         cycle();
      end

      // 5. full with push+pop: pop only
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 1'b0, 32'h200 + k, k);
         cycle();
      end
      set_in(1'b1, 1'b1, 32'h2ff, 7);
      cycle();
      chk("t5_count", 160'(o9), 160'(3));
      chk("t5_ready", 160'(o1), 160'(1));

      // 6. reset mid-stream discards the concurrent push
      i2 = 1'b1;
      set_in(1'b1, 1'b0, 32'h300, 9);
      cycle();
      chk("t6_count", 160'(o9), 160'(0));
      chk("t6_valid", 160'(o2), 160'(0));
      chk("t6_drop", 160'(o10), 160'(0));
      chk("t6_hwm", 160'(o11), 160'(0));
      i2 = 1'b0;
      set_in(1'b0, 1'b0, 0, 0);
      cycle();
      chk("t6_idle", 160'(o9), 160'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
